// File: rtl/tmds_pkg.sv
// Shared constants and code tables for the multi-lane TMDS/HDMI encoder.
package tmds_pkg;

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_DGUARD = 3'd3;
    localparam logic [2:0] MODE_ISLAND = 3'd4;

    localparam logic [9:0] TMDS_RESET = 10'b1101010100;
    localparam logic [9:0] GB_A       = 10'b1011001100;
    localparam logic [9:0] GB_B       = 10'b0100110011;

    // Control-period code for {C1,C0}.
    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] w;
        case (c)
            2'b00:   w = 10'b1101010100;
            2'b01:   w = 10'b0010101011;
            2'b10:   w = 10'b0101010100;
            2'b11:   w = 10'b1010101011;
            default: w = 10'b1101010100;
        endcase
        return w;
    endfunction

    // HDMI TERC4 data-island symbol table.
    function automatic logic [9:0] terc4(input logic [3:0] t);
        logic [9:0] w;
        case (t)
            4'h0:    w = 10'b1010011100;
            4'h1:    w = 10'b1001100011;
            4'h2:    w = 10'b1011100100;
            4'h3:    w = 10'b1011100010;
            4'h4:    w = 10'b0101110001;
            4'h5:    w = 10'b0100011110;
            4'h6:    w = 10'b0110001110;
            4'h7:    w = 10'b0100111100;
            4'h8:    w = 10'b1011001100;
            4'h9:    w = 10'b0100111001;
            4'hA:    w = 10'b0110011100;
            4'hB:    w = 10'b1011000110;
            4'hC:    w = 10'b1010001110;
            4'hD:    w = 10'b1001110001;
            4'hE:    w = 10'b0101100011;
            4'hF:    w = 10'b1011000011;
            default: w = 10'b1010011100;
        endcase
        return w;
    endfunction

    // Number of ones in a byte.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimised word q_m[8:0]; q_m[8]=1 means the XOR chain was used.
    function automatic logic [8:0] dvi_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = 9'd0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

endpackage

// File: rtl/tmds_enc_lane.sv
// One TMDS lane: stage 1 builds q_m, stage 2 picks the output word and tracks disparity.
module tmds_enc_lane
    import tmds_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic [7:0] vd,
    input  logic [1:0] cd,
    input  logic [3:0] terc,
    output logic [9:0] tmds
);

    localparam logic [1:0] LANE_MOD = 2'(LANE % 3);

    logic [8:0]        qm_d, qm_q;
    logic [3:0]        n1_d, n1_q;
    logic [2:0]        md_d, md_q;
    logic [1:0]        cd_d, cd_q;
    logic [3:0]        terc_d, terc_q;
    logic [9:0]        tmds_d, tmds_q;
    logic signed [4:0] cnt_d, cnt_q;
    logic signed [5:0] diff_s, cnt_ext_s, cnt_sum_s;
    logic              q8_s;

    // Stage 1 next-state: q_m, its ones count, and the side-band inputs.
    always_comb begin
        qm_d   = dvi_qm(vd);
        n1_d   = popcount8(qm_d[7:0]);
        md_d   = mode;
        cd_d   = cd;
        terc_d = terc;
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qm_q   <= 9'd0;
            n1_q   <= 4'd0;
            md_q   <= MODE_CTRL;
            cd_q   <= 2'b00;
            terc_q <= 4'd0;
        end else begin
            qm_q   <= qm_d;
            n1_q   <= n1_d;
            md_q   <= md_d;
            cd_q   <= cd_d;
            terc_q <= terc_d;
        end
    end

    // Stage 2 word selection; diff_s is N1-N0 of q_m[7:0], cnt only survives VIDEO.
    always_comb begin
        q8_s      = qm_q[8];
        diff_s    = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
        cnt_ext_s = {cnt_q[4], cnt_q};
        cnt_sum_s = 6'sd0;
        tmds_d    = TMDS_RESET;
        case (md_q)
            MODE_VIDEO: begin
                if ((cnt_q == 5'sd0) || (diff_s == 6'sd0)) begin
                    tmds_d    = {~q8_s, q8_s, q8_s ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_sum_s = q8_s ? (cnt_ext_s + diff_s) : (cnt_ext_s - diff_s);
                end else if (cnt_q[4] == diff_s[5]) begin
                    // Both nonzero with equal sign: running disparity and word lean the same way.
                    tmds_d    = {1'b1, q8_s, ~qm_q[7:0]};
                    cnt_sum_s = cnt_ext_s + (q8_s ? 6'sd2 : 6'sd0) - diff_s;
                end else begin
                    tmds_d    = {1'b0, q8_s, qm_q[7:0]};
                    cnt_sum_s = cnt_ext_s + diff_s - (q8_s ? 6'sd0 : 6'sd2);
                end
            end
            MODE_VGUARD: tmds_d = (LANE_MOD == 2'd1) ? GB_B : GB_A;
            MODE_DGUARD: tmds_d = (LANE_MOD == 2'd0) ? terc4({2'b11, cd_q}) : GB_B;
            MODE_ISLAND: tmds_d = terc4(terc_q);
            default:     tmds_d = ctrl_code(cd_q);
        endcase
        cnt_d = 5'(cnt_sum_s);
    end

    // Stage 2 registers: output word and running disparity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmds_q <= TMDS_RESET;
            cnt_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// NCH-lane TMDS/HDMI encoder with a 2-cycle pipeline and a sticky guard-sequence monitor.
module tmds_multi_encoder
    import tmds_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int GBLEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        mode,
    input  logic [8*NCH-1:0]  vd,
    input  logic [2*NCH-1:0]  cd,
    input  logic [4*NCH-1:0]  terc,
    output logic [10*NCH-1:0] tmds,
    output logic [2:0]        mode_q,
    output logic              seq_err
);

    localparam logic [2:0] GBLEN_W = 3'(GBLEN);

    logic [2:0] mode_n_s;
    logic [2:0] mode_s1_d, mode_s1_q;
    logic [2:0] mode_d;
    logic [2:0] gcnt_d, gcnt_q;
    logic       seq_err_d, seq_err_q;
    logic       cur_guard_s, entry_bad_s;

    // Fold the undefined mode codes onto CTRL so every lane and mode_q agree.
    always_comb begin
        if (mode > MODE_ISLAND) begin
            mode_n_s = MODE_CTRL;
        end else begin
            mode_n_s = mode;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        tmds_enc_lane #(.LANE(i)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .mode  (mode_n_s),
            .vd    (vd[8*i +: 8]),
            .cd    (cd[2*i +: 2]),
            .terc  (terc[4*i +: 4]),
            .tmds  (tmds[10*i +: 10])
        );
    end

    // Guard monitor: mode_s1_q is the current word, mode_q the previous one, gcnt_q its guard run.
    always_comb begin
        mode_s1_d   = mode_n_s;
        mode_d      = mode_s1_q;
        cur_guard_s = (mode_s1_q == MODE_VGUARD) || (mode_s1_q == MODE_DGUARD);
        if (cur_guard_s) begin
            if (gcnt_q == 3'd7) begin
                gcnt_d = 3'd7;
            end else begin
                gcnt_d = gcnt_q + 3'd1;
            end
        end else begin
            gcnt_d = 3'd0;
        end
        if ((mode_s1_q == MODE_VIDEO) && (mode_q != MODE_VIDEO)) begin
            entry_bad_s = (mode_q != MODE_VGUARD) || (gcnt_q != GBLEN_W);
        end else if ((mode_s1_q == MODE_ISLAND) && (mode_q != MODE_ISLAND)) begin
            entry_bad_s = (mode_q != MODE_DGUARD) || (gcnt_q != GBLEN_W);
        end else begin
            entry_bad_s = 1'b0;
        end
        seq_err_d = seq_err_q | entry_bad_s;
    end

    // Mode pipeline, guard run counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_s1_q <= MODE_CTRL;
            mode_q    <= MODE_CTRL;
            gcnt_q    <= 3'd0;
            seq_err_q <= 1'b0;
        end else begin
            mode_s1_q <= mode_s1_d;
            mode_q    <= mode_d;
            gcnt_q    <= gcnt_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Scoreboard bench for tmds_multi_encoder with a behavioural reference model.
module tb_tmds_multi_encoder;

    localparam int NCH   = 3;
    localparam int GBLEN = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        mode  = 3'd0;
    logic [8*NCH-1:0]  vd    = '0;
    logic [2*NCH-1:0]  cd    = '0;
    logic [4*NCH-1:0]  terc  = '0;
    logic [10*NCH-1:0] tmds;
    logic [2:0]        mode_q;
    logic              seq_err;

    tmds_multi_encoder #(.NCH(NCH), .GBLEN(GBLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .vd      (vd),
        .cd      (cd),
        .terc    (terc),
        .tmds    (tmds),
        .mode_q  (mode_q),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                due;
        logic [10*NCH-1:0] tmds;
        logic [2:0]        mode;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int m_cnt [NCH];
    int m_prev = 0;
    int m_run  = 0;
    bit m_err  = 1'b0;

    function automatic logic [9:0] ctrl_ref(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc_ref(input logic [3:0] t);
        case (t)
            4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;  default: return 10'b1011000011;
        endcase
    endfunction

    // DVI video word: q_m bit i is the prefix parity of d, odd bits inverted in XNOR mode.
    task automatic video_ref(input int lane, input logic [7:0] d, output logic [9:0] w);
        int         n1, n1q, n0q, q8;
        logic [7:0] qm;
        logic       p;
        bit         xn;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        p  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p     = p ^ d[i];
            qm[i] = p ^ (xn && (i % 2 == 1));
        end
        q8  = xn ? 0 : 1;
        n1q = $countones(qm);
        n0q = 8 - n1q;
        if (m_cnt[lane] == 0 || n1q == n0q) begin
            w = {(q8 == 0), (q8 == 1), (q8 == 1) ? qm : ~qm};
            m_cnt[lane] += (q8 == 1) ? (n1q - n0q) : (n0q - n1q);
        end else if ((m_cnt[lane] > 0 && n1q > n0q) || (m_cnt[lane] < 0 && n0q > n1q)) begin
            w = {1'b1, (q8 == 1), ~qm};
            m_cnt[lane] += 2 * q8 + n0q - n1q;
        end else begin
            w = {1'b0, (q8 == 1), qm};
            m_cnt[lane] += n1q - n0q - 2 * (1 - q8);
        end
    endtask

    task automatic model_step(input bit rst, input logic [2:0] md, input logic [8*NCH-1:0] v,
                              input logic [2*NCH-1:0] c, input logic [4*NCH-1:0] t);
        exp_t       e;
        int         m;
        bit         bad;
        logic [9:0] w;
        if (rst) begin
            e.tmds = {NCH{10'b1101010100}};
            e.mode = 3'd0;
            e.err  = 1'b0;
            e.due  = cyc + 1;
            if (sb.size() > 0 && sb[sb.size()-1].due == cyc + 1) begin
                void'(sb.pop_back());
            end
            sb.push_back(e);
            e.due = cyc + 2;
            sb.push_back(e);
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            m_prev = 0;
            m_run  = 0;
            m_err  = 1'b0;
        end else begin
            m   = (md > 3'd4) ? 0 : int'(md);
            bad = 1'b0;
            if (m == 1 && m_prev != 1) bad = (m_prev != 2) || (m_run != GBLEN);
            else if (m == 4 && m_prev != 4) bad = (m_prev != 3) || (m_run != GBLEN);
            if (bad) m_err = 1'b1;
            m_run  = (m == 2 || m == 3) ? ((m_run < 7) ? m_run + 1 : 7) : 0;
            m_prev = m;
            for (int i = 0; i < NCH; i++) begin
                case (m)
                    1:       video_ref(i, v[8*i +: 8], w);
                    2:       w = (i % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
                    3:       w = (i % 3 == 0) ? terc_ref({2'b11, c[2*i +: 2]}) : 10'b0100110011;
                    4:       w = terc_ref(t[4*i +: 4]);
                    default: w = ctrl_ref(c[2*i +: 2]);
                endcase
                if (m != 1) m_cnt[i] = 0;
                e.tmds[10*i +: 10] = w;
            end
            e.mode = 3'(m);
            e.err  = m_err;
            e.due  = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic step(input bit rst, input logic [2:0] md, input logic [8*NCH-1:0] v,
                        input logic [2*NCH-1:0] c, input logic [4*NCH-1:0] t);
        @(posedge clk);
        #1;
        rst_n = !rst;
        mode  = md;
        vd    = v;
        cd    = c;
        terc  = t;
        model_step(rst, md, v, c, t);
    endtask

    // Monitor: compare every word whose due cycle has arrived.
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL late_entry cyc=%0d due=%0d", cyc, e.due);
            end else begin
                n_cmp++;
                if (tmds !== e.tmds) begin
                    n_bad++;
                    $display("FAIL tmds cyc=%0d got=%b exp=%b", cyc, tmds, e.tmds);
                end
                n_cmp++;
                if (mode_q !== e.mode) begin
                    n_bad++;
                    $display("FAIL mode_q cyc=%0d got=%0d exp=%0d", cyc, mode_q, e.mode);
                end
                n_cmp++;
                if (seq_err !== e.err) begin
                    n_bad++;
                    $display("FAIL seq_err cyc=%0d got=%b exp=%b", cyc, seq_err, e.err);
                end
            end
        end
    end

    initial begin
        logic [2:0] md;
        int         run;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;

        // reset, then release in CTRL with cd=0
        repeat (3) step(1'b1, 3'd0, '0, '0, '0);
        repeat (3) step(1'b0, 3'd0, '0, '0, '0);
        // two all-zero video words: disparity -8 then +2
        repeat (2) step(1'b0, 3'd1, '0, '0, '0);
        // control codes
        for (int c = 0; c < 4; c++) step(1'b0, 3'd0, '0, {NCH{2'(c)}}, '0);
        // legal video preamble
        step(1'b1, 3'd0, '0, '0, '0);
        step(1'b0, 3'd0, '0, '0, '0);
        repeat (2) step(1'b0, 3'd2, '0, '0, '0);
        repeat (3) step(1'b0, 3'd1, 24'($urandom), '0, '0);
        step(1'b0, 3'd0, '0, '0, '0);
        // short preamble: error must stick
        step(1'b0, 3'd2, '0, '0, '0);
        step(1'b0, 3'd1, 24'($urandom), '0, '0);
        repeat (3) step(1'b0, 3'd0, '0, '0, '0);
        // data island with guard bands
        step(1'b1, 3'd0, '0, '0, '0);
        step(1'b0, 3'd0, '0, '0, '0);
        repeat (2) step(1'b0, 3'd3, '0, {NCH{2'b01}}, '0);
        repeat (2) step(1'b0, 3'd4, '0, '0, '0);
        repeat (2) step(1'b0, 3'd3, '0, {NCH{2'b01}}, '0);
        step(1'b0, 3'd0, '0, '0, '0);

        // randomized mode runs, with periodic resets and legal preambles
        for (int k = 0; k < 70; k++) begin
            if (k % 8 == 0) step(1'b1, 3'd0, '0, '0, '0);
            if (k % 4 == 1) begin
                step(1'b0, 3'd0, '0, 6'($urandom), '0);
                md = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
                repeat (2) step(1'b0, md, '0, 6'($urandom), '0);
                md = (md == 3'd2) ? 3'd1 : 3'd4;
            end else begin
                md = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0) md = 3'd1;
            end
            run = $urandom_range(1, 10);
            for (int j = 0; j < run; j++) begin
                step(($urandom_range(0, 99) == 0), md, 24'($urandom), 6'($urandom), 12'($urandom));
            end
        end
        step(1'b0, 3'd0, '0, '0, '0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout left=%0d", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
